default_chan_block_dac_fifo: RTL and testbench
==============================================

// Module: default_chan_block_dac_fifo
// PURPOSE
//  Rate-decoupling FIFO between default_chan_block_dac (fabric clk, bursty valid/ready)
//  and the AD9361 DAC core (one sample per dac_valid strobe, same clk).
//  Reports free space (room) and empty upstream so the block can pad and flag underflow.
//  Replays zero samples to the DAC when empty; counts underrun events for status.
// PARAMETERS
//  DEPTH_LOG2  9   log2 of FIFO depth (512 entries); room port is DEPTH_LOG2+1 bits
//  DATA_W      64  sample word width {q1,i1,q0,i0}, 16 bits each
// PORTS
//  clk              in   1       fabric clock; the block's only clock
//  reset            in   1       reset, asynchronous, active-high
//  s_ready          out  1       FIFO can accept a word (not full)
//  s_valid          in   1       upstream word valid
//  s_data           in   64      upstream sample word
//  s_room           out  10      free entries, 0..512
//  s_empty          out  1       occupancy == 0
//  s_enables        out  4       registered copy of dac_enable, per I/Q lane
//  dac_enable       in   4       lane enables from DAC core {q1,i1,q0,i0}
//  dac_valid        in   1       DAC sample strobe; one pop request per high cycle
//  dac_data         out  64      sample presented to DAC core
//  dac_data_valid   out  1       one-cycle pulse: dac_data updated this cycle
//  underrun_stb     out  1       one-cycle pulse: a pop request found FIFO empty
//  underrun_count   out  32      saturating count of underrun_stb pulses
//  underrun_clear   in   1       synchronous clear of underrun_count
// BEHAVIOUR
//  Reset (async assert, sync release): count=0, rd/wr ptr=0, s_room=512, s_empty=1,
//   s_ready=1, dac_data=0, dac_data_valid=0, underrun_stb=0, underrun_count=0, s_enables=0.
//  Storage: DEPTH x DATA_W simple dual-port RAM, DEPTH_LOG2-bit wrapping pointers,
//   separate (DEPTH_LOG2+1)-bit count register; full = count==DEPTH.
//  Push = s_valid & s_ready; s_ready = ~full (combinational from count register).
//  Pop request = dac_valid. If count!=0: read RAM[rd_ptr], rd_ptr++, count--.
//   If count==0: no pointer change, underrun_stb=1, dac_data loaded with 0.
//  Read latency: dac_data and dac_data_valid update exactly 1 cycle after dac_valid;
//   dac_data holds its value between strobes. Masking by enables is upstream's job.
//  No fall-through: a word pushed in cycle N is poppable from cycle N+1; push and pop
//   in the same cycle while empty yields an underrun (zeros) and count ends at 1.
//  Simultaneous push & pop with count in 1..DEPTH-1: count unchanged, both ptrs advance.
//  Full: s_ready=0, pop still allowed; room returns to 1 the next cycle.
//  s_room = DEPTH - count, s_empty = (count==0); both registered with count (no extra lag).
//  Pointer wrap: 511 -> 0 transparently; data order preserved across wrap.
//  underrun_count saturates at 32'hFFFF_FFFF; underrun_clear wins over a same-cycle
//   increment (count becomes 0).
//  s_enables = dac_enable delayed one clk.
//  Reset mid-operation discards all contents; no handshake is completed during reset.
// STRUCTURE
//  Shared header default_chan_dac_defs.vh: DAC_FIFO_DEPTH_LOG2, DAC_SAMPLE_W,
//   DAC_ZERO_SAMPLE (64'h0), lane index constants for {q1,i1,q0,i0}.
//  One sub-module: rwt_sdp_ram (DEPTH x WIDTH, registered read port, no reset on array).
//  Control (ptrs, count, underrun logic) lives in this module.
// TESTING
//  T1 reset then 3 pushes A,B,C, then dac_valid x3 -> dac_data A,B,C one cycle after
//     each strobe, room 509->512, s_empty=1 at end, underrun_count=0.
//  T2 dac_valid while empty -> dac_data=0, underrun_stb 1 cycle, underrun_count=1.
//  T3 512 pushes with no pops -> s_ready=0, s_room=0; 513th s_valid held until one
//     pop, then accepted next cycle; all 513 words drain in order.
//  T4 continuous push+pop every cycle at count=100 for 2000 cycles -> count fixed at
//     100, pointers wrap, output sequence matches input with 100-word lag.
//  T5 push and dac_valid same cycle when empty -> underrun_stb=1, dac_data=0, count=1.
//  T6 reset asserted mid-stream at count=37 -> all outputs at reset values
//     asynchronously; after release first pop reports underrun; underrun_count
//     forced to 32'hFFFF_FFFF saturates; clear + underrun same cycle -> 0.

Source files
------------

// File: rtl/default_chan_block_dac_fifo_pkg.sv
// Shared constants and types for the DAC-side sample FIFO.
package default_chan_block_dac_fifo_pkg;

    localparam int unsigned DAC_FIFO_DEPTH_LOG2 = 9;
    localparam int unsigned DAC_SAMPLE_W        = 64;
    localparam int unsigned DAC_LANES           = 4;
    localparam logic [63:0] DAC_ZERO_SAMPLE     = 64'h0;

    // Lane order within a sample word and within dac_enable: {q1,i1,q0,i0}
    localparam int unsigned DAC_LANE_I0 = 0;
    localparam int unsigned DAC_LANE_Q0 = 1;
    localparam int unsigned DAC_LANE_I1 = 2;
    localparam int unsigned DAC_LANE_Q1 = 3;

    typedef struct packed {
        logic [15:0] q1;
        logic [15:0] i1;
        logic [15:0] q0;
        logic [15:0] i0;
    } dac_sample_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/default_chan_block_dac_fifo_rwt_sdp_ram.sv
// Simple dual-port RAM, one write port, one registered read port, no array reset.
module rwt_sdp_ram #(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned WIDTH      = 64
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; holds its value when not enabled
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/default_chan_block_dac_fifo.sv
// Rate-decoupling FIFO from the fabric sample stream to the DAC strobe domain.
// Replays zeros on underrun and keeps a saturating underrun counter.
module default_chan_block_dac_fifo
    import default_chan_block_dac_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DAC_FIFO_DEPTH_LOG2,
    parameter int unsigned DATA_W     = DAC_SAMPLE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  s_ready,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    output logic [DEPTH_LOG2:0]   s_room,
    output logic                  s_empty,
    output logic [DAC_LANES-1:0]  s_enables,
    input  logic [DAC_LANES-1:0]  dac_enable,
    input  logic                  dac_valid,
    output logic [DATA_W-1:0]     dac_data,
    output logic                  dac_data_valid,
    output logic                  underrun_stb,
    output logic [31:0]           underrun_count,
    input  logic                  underrun_clear
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        room_q, room_d;
    logic                 empty_q, empty_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 zero_q, zero_d;
    logic                 dv_q, dv_d;
    logic                 stb_q, stb_d;
    logic [31:0]          urc_q, urc_d;
    logic [DAC_LANES-1:0] en_q;
    logic [DATA_W-1:0]    ram_rd_data;

    logic full_c, push_c, pop_c, underrun_c;

    // Handshake decode from the registered occupancy
    assign full_c     = (count_q == CW'(DEPTH));
    assign push_c     = s_valid & ~full_c;
    assign pop_c      = dac_valid & (count_q != CW'(0));
    assign underrun_c = dac_valid & (count_q == CW'(0));

    // Next-state for pointers, occupancy, status and underrun tracking
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        zero_d   = zero_q;
        urc_d    = urc_q;
        dv_d     = dac_valid;
        stb_d    = underrun_c;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        room_d  = CW'(DEPTH) - count_d;
        empty_d = (count_d == CW'(0));

        // Output word comes from RAM after a real pop, zeros after an underrun
        if (pop_c) begin
            zero_d = 1'b0;
        end else if (underrun_c) begin
            zero_d = 1'b1;
        end

        if (underrun_clear) begin
            urc_d = 32'd0;
        end else if (underrun_c) begin
            urc_d = sat_inc32(urc_q);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            room_q   <= CW'(DEPTH);
            empty_q  <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            zero_q   <= 1'b1;
            dv_q     <= 1'b0;
            stb_q    <= 1'b0;
            urc_q    <= 32'd0;
            en_q     <= '0;
        end else begin
            count_q  <= count_d;
            room_q   <= room_d;
            empty_q  <= empty_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            zero_q   <= zero_d;
            dv_q     <= dv_d;
            stb_q    <= stb_d;
            urc_q    <= urc_d;
            en_q     <= dac_enable;
        end
    end

    rwt_sdp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DATA_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (push_c),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (s_data),
        .rd_en_i   (pop_c),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

    assign s_ready        = ~full_c;
    assign s_room         = room_q;
    assign s_empty        = empty_q;
    assign s_enables      = en_q;
    assign dac_data       = zero_q ? DATA_W'(DAC_ZERO_SAMPLE) : ram_rd_data;
    assign dac_data_valid = dv_q;
    assign underrun_stb   = stb_q;
    assign underrun_count = urc_q;

endmodule

// File: tb/tb_default_chan_block_dac_fifo.sv
// Bench for default_chan_block_dac_fifo: queue-based reference model plus directed scenarios.
module tb_default_chan_block_dac_fifo;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_ready;
    logic        s_valid = 1'b0;
    logic [63:0] s_data = 64'h0;
    logic [9:0]  s_room;
    logic        s_empty;
    logic [3:0]  s_enables;
    logic [3:0]  dac_enable = 4'h0;
    logic        dac_valid = 1'b0;
    logic [63:0] dac_data;
    logic        dac_data_valid;
    logic        underrun_stb;
    logic [31:0] underrun_count;
    logic        underrun_clear = 1'b0;
    logic        preload = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    default_chan_block_dac_fifo dut (
        .clk            (clk),
        .reset          (reset),
        .s_ready        (s_ready),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_room         (s_room),
        .s_empty        (s_empty),
        .s_enables      (s_enables),
        .dac_enable     (dac_enable),
        .dac_valid      (dac_valid),
        .dac_data       (dac_data),
        .dac_data_valid (dac_data_valid),
        .underrun_stb   (underrun_stb),
        .underrun_count (underrun_count),
        .underrun_clear (underrun_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words, applied at each clock edge
    logic [63:0] mq[$];
    logic [63:0] m_dd;
    logic        m_dv, m_us;
    logic [31:0] m_urc;
    logic [3:0]  m_en;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_dd  = 64'h0;
            m_dv  = 1'b0;
            m_us  = 1'b0;
            m_urc = 32'h0;
            m_en  = 4'h0;
        end else begin
            automatic bit can_push = (mq.size() < DEPTH);
            if (preload) m_urc = 32'hFFFF_FFFF;
            m_dv = dac_valid;
            m_us = 1'b0;
            if (dac_valid) begin
                if (mq.size() > 0) begin
                    m_dd = mq.pop_front();
                end else begin
                    m_dd = 64'h0;
                    m_us = 1'b1;
                end
            end
            if (underrun_clear)                     m_urc = 32'h0;
            else if (m_us && m_urc != 32'hFFFF_FFFF) m_urc = m_urc + 32'd1;
            if (s_valid && can_push) mq.push_back(s_data);
            m_en = dac_enable;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("s_ready",        64'(s_ready),        64'(mq.size() < DEPTH));
            chk("s_room",         64'(s_room),         64'(DEPTH - mq.size()));
            chk("s_empty",        64'(s_empty),        64'(mq.size() == 0));
            chk("s_enables",      64'(s_enables),      64'(m_en));
            chk("dac_data",       dac_data,            m_dd);
            chk("dac_data_valid", 64'(dac_data_valid), 64'(m_dv));
            chk("underrun_stb",   64'(underrun_stb),   64'(m_us));
            if (!preload) chk("underrun_count", 64'(underrun_count), 64'(m_urc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [63:0] word(input int i);
        return {32'(i), ~32'(i)};
    endfunction

    task automatic reset_literals(input string tag);
        chk({tag, "_room"},  64'(s_room),         64'd512);
        chk({tag, "_empty"}, 64'(s_empty),        64'd1);
        chk({tag, "_ready"}, 64'(s_ready),        64'd1);
        chk({tag, "_data"},  dac_data,            64'h0);
        chk({tag, "_dv"},    64'(dac_data_valid), 64'd0);
        chk({tag, "_stb"},   64'(underrun_stb),   64'd0);
        chk({tag, "_urc"},   64'(underrun_count), 64'd0);
        chk({tag, "_en"},    64'(s_enables),      64'd0);
    endtask

    initial begin
        tick();
        tick();
        reset_literals("rst");
        reset = 1'b0;
        dac_enable = 4'b1111;
        tick();

        // T1: three pushes then three pops
        s_valid = 1'b1; s_data = 64'hAAAA_0000_AAAA_0001; tick();
        s_data = 64'hBBBB_0000_BBBB_0002; tick();
        s_data = 64'hCCCC_0000_CCCC_0003; tick();
        s_valid = 1'b0;
        chk("t1_room3", 64'(s_room), 64'd509);
        dac_valid = 1'b1; tick();
        chk("t1_a", dac_data, 64'hAAAA_0000_AAAA_0001);
        chk("t1_dv", 64'(dac_data_valid), 64'd1);
        tick();
        chk("t1_b", dac_data, 64'hBBBB_0000_BBBB_0002);
        tick();
        chk("t1_c", dac_data, 64'hCCCC_0000_CCCC_0003);
        dac_valid = 1'b0; dac_enable = 4'b0101; tick();
        chk("t1_room_end", 64'(s_room), 64'd512);
        chk("t1_empty", 64'(s_empty), 64'd1);
        chk("t1_urc", 64'(underrun_count), 64'd0);
        chk("t1_hold", dac_data, 64'hCCCC_0000_CCCC_0003);
        chk("t1_en", 64'(s_enables), 64'd5);

        // T2: pop while empty
        dac_valid = 1'b1; tick();
        chk("t2_data", dac_data, 64'h0);
        chk("t2_stb", 64'(underrun_stb), 64'd1);
        chk("t2_urc", 64'(underrun_count), 64'd1);
        dac_valid = 1'b0; tick();
        chk("t2_stb_off", 64'(underrun_stb), 64'd0);

        // T3: fill to full, hold a 513th word, pop once, drain all
        s_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            s_data = word(1000 + i);
            tick();
        end
        s_data = word(1512);
        chk("t3_ready_full", 64'(s_ready), 64'd0);
        chk("t3_room_full", 64'(s_room), 64'd0);
        tick(); tick(); tick();
        chk("t3_still_full", 64'(s_room), 64'd0);
        dac_valid = 1'b1; tick();
        dac_valid = 1'b0;
        chk("t3_room1", 64'(s_room), 64'd1);
        chk("t3_first", dac_data, word(1000));
        tick();
        s_valid = 1'b0;
        chk("t3_refull", 64'(s_room), 64'd0);
        dac_valid = 1'b1;
        for (int i = 0; i < 512; i++) tick();
        chk("t3_last", dac_data, word(1512));
        dac_valid = 1'b0; tick();

        // T4: steady push+pop at occupancy 100 across pointer wraps
        s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = word(5000 + i);
            tick();
        end
        dac_valid = 1'b1;
        for (int i = 100; i < 2100; i++) begin
            s_data = word(5000 + i);
            tick();
        end
        s_valid = 1'b0;
        chk("t4_room", 64'(s_room), 64'd412);
        chk("t4_lag", dac_data, word(5000 + 1999));
        for (int i = 0; i < 100; i++) tick();
        dac_valid = 1'b0; tick();
        chk("t4_empty", 64'(s_empty), 64'd1);

        // T5: push and pop in the same cycle while empty
        s_valid = 1'b1; s_data = 64'h5555_AAAA_5555_AAAA; dac_valid = 1'b1; tick();
        s_valid = 1'b0;
        chk("t5_stb", 64'(underrun_stb), 64'd1);
        chk("t5_data", dac_data, 64'h0);
        chk("t5_room", 64'(s_room), 64'd511);
        tick();
        chk("t5_pop", dac_data, 64'h5555_AAAA_5555_AAAA);
        dac_valid = 1'b0; tick();

        // T6: async reset mid-stream, then saturation and clear priority
        s_valid = 1'b1;
        for (int i = 0; i < 37; i++) begin
            s_data = word(9000 + i);
            tick();
        end
        chk("t6_room37", 64'(s_room), 64'd475);
        reset = 1'b1;
        #1;
        reset_literals("t6_async");
        s_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        dac_valid = 1'b1; tick();
        dac_valid = 1'b0;
        chk("t6_first_underrun", 64'(underrun_stb), 64'd1);
        chk("t6_urc1", 64'(underrun_count), 64'd1);
        preload = 1'b1;
        force dut.urc_q = 32'hFFFF_FFFF;
        #1;
        release dut.urc_q;
        dac_valid = 1'b1; tick();
        preload = 1'b0;
        chk("t6_sat", 64'(underrun_count), 64'hFFFF_FFFF);
        underrun_clear = 1'b1; tick();
        underrun_clear = 1'b0; dac_valid = 1'b0;
        chk("t6_clear_wins", 64'(underrun_count), 64'd0);
        chk("t6_clear_stb", 64'(underrun_stb), 64'd1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
